// File: rtl/mac_vec_v3.sv
// mac_vec_v3: pipelined signed/unsigned dot-product MAC with ready/valid input,
// explicit last flag, LEN-limit closing and a fixed 3-edge result latency.
module mac_vec_v3 #(
  parameter int unsigned DW    = 4,
  parameter int unsigned LEN   = 8,
  parameter int unsigned ACC_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in1_IFM,
  input  logic [DW-1:0]    in2_IFM,
  input  logic             in_last,
  input  logic             signed_mode,
  output logic [ACC_W-1:0] out,
  output logic             out_valid,
  output logic             len_err
);

  localparam int unsigned PW = 2 * DW;
  localparam int unsigned CW = (LEN > 1) ? $clog2(LEN) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             drain_q, drain_d;
  logic             in_ready_q, in_ready_d;
  logic [CW-1:0]    cnt_q;
  logic             mode_q;
  logic             lerr_q;

  logic             s1_valid_q, s1_first_q, s1_mode_q;
  logic [DW-1:0]    s1_a_q, s1_b_q;
  logic             s2_valid_q, s2_first_q, s2_mode_q;
  logic [PW-1:0]    s2_prod_q;
  logic [ACC_W-1:0] acc_q;

  logic             accept_c, final_c, first_c, mode_c;
  logic [PW-1:0]    sa_c, sb_c, sprod_c, uprod_c;
  logic [ACC_W-1:0] ext_c;

  assign in_ready = in_ready_q;
  assign accept_c = in_valid && in_ready_q;
  assign first_c  = (state_q == ST_IDLE);
  assign final_c  = in_last || (cnt_q == CW'(LEN - 1));
  assign mode_c   = first_c ? signed_mode : mode_q;

  // Next-state logic; in_ready is precomputed from the next state so it is a flop.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE: begin
        drain_d = 1'b0;
        if (accept_c) state_d = final_c ? ST_DRAIN : ST_ACC;
      end
      ST_ACC: begin
        if (accept_c && final_c) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        drain_d = ~drain_q;
        if (drain_q) state_d = ST_OUT;
      end
      ST_OUT: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_IDLE) || (state_d == ST_ACC);
  end

  // FSM state, element counter, per-vector mode and LEN-limit flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      drain_q    <= 1'b0;
      in_ready_q <= 1'b1;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
      lerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      in_ready_q <= in_ready_d;
      if (accept_c) begin
        cnt_q <= final_c ? '0 : cnt_q + CW'(1);
        if (first_c) mode_q <= signed_mode;
        if (final_c) lerr_q <= ~in_last;
      end
    end
  end

  // S1: operand capture with first tag and the vector's mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_mode_q  <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
    end else begin
      s1_valid_q <= accept_c;
      if (accept_c) begin
        s1_first_q <= first_c;
        s1_mode_q  <= mode_c;
        s1_a_q     <= in1_IFM;
        s1_b_q     <= in2_IFM;
      end
    end
  end

  // Low PW bits of the product of sign-extended operands equal the signed product.
  assign sa_c    = {{DW{s1_a_q[DW-1]}}, s1_a_q};
  assign sb_c    = {{DW{s1_b_q[DW-1]}}, s1_b_q};
  assign sprod_c = sa_c * sb_c;
  assign uprod_c = PW'(s1_a_q) * PW'(s1_b_q);

  // S2: product register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_first_q <= 1'b0;
      s2_mode_q  <= 1'b0;
      s2_prod_q  <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_first_q <= s1_first_q;
        s2_mode_q  <= s1_mode_q;
        s2_prod_q  <= s1_mode_q ? sprod_c : uprod_c;
      end
    end
  end

  assign ext_c = s2_mode_q ? {{(ACC_W - PW){s2_prod_q[PW-1]}}, s2_prod_q}
                           : {{(ACC_W - PW){1'b0}}, s2_prod_q};

  // S3: a first-tagged product loads the accumulator, later ones add (wrapping).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (s2_valid_q) begin
      acc_q <= s2_first_q ? ext_c : acc_q + ext_c;
    end
  end

  // Result registers: present the accumulator for one cycle from OUT, else zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
      len_err   <= 1'b0;
    end else if (state_q == ST_OUT) begin
      out       <= acc_q;
      out_valid <= 1'b1;
      len_err   <= lerr_q;
    end else begin
      out       <= '0;
      out_valid <= 1'b0;
      len_err   <= 1'b0;
    end
  end

endmodule
